// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode/immediate at pc and hands them to decode via a one-entry output register.
// Latency: instruction at pc appears on ir_* one edge after it is read; a redirect costs exactly one bubble.
// Backpressure: while ir_valid && !ir_ready the output register holds and pc_en stays low (pc frozen).
module fetch_unit #(
    parameter logic [7:0] HALT_OP = 8'hFF,
    parameter int         IMM_BIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pc,
    output logic [7:0]  imem_addr,
    input  logic [7:0]  imem_byte0,
    input  logic [7:0]  imem_byte1,
    output logic        pc_en,
    output logic        pc_load,
    output logic        pc_imm,
    output logic [7:0]  pc_target,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [7:0]  ir_opcode,
    output logic [7:0]  ir_imm,
    output logic [7:0]  ir_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   slot_free;
    logic   do_fetch;
    logic   do_flush;
    logic   is_imm;

    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign slot_free = !ir_valid || ir_ready;
    assign is_imm    = imem_byte0[IMM_BIT];

    // State register; reset always lands in BOOT for one idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and program-counter control; a redirect outranks both fetch and halt.
    always_comb begin
        state_nxt = state;
        do_fetch  = 1'b0;
        do_flush  = 1'b0;
        pc_en     = 1'b0;
        pc_load   = 1'b0;
        pc_imm    = 1'b0;
        pc_target = br_taken ? br_target : 8'h00;
        unique case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (br_taken) begin
                    pc_en     = 1'b1;
                    pc_load   = 1'b1;
                    do_flush  = 1'b1;
                end else if (slot_free) begin
                    do_fetch = 1'b1;
                    if (imem_byte0 == HALT_OP) begin
                        // Halt opcode still goes to decode, but the pc stops on it.
                        state_nxt = ST_HALT;
                    end else begin
                        pc_en  = 1'b1;
                        pc_imm = is_imm;
                    end
                end
            end
            ST_HALT: begin
                if (br_taken) begin
                    pc_en     = 1'b1;
                    pc_load   = 1'b1;
                    do_flush  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
        if (rst) begin
            do_fetch = 1'b0;
            do_flush = 1'b0;
            pc_en    = 1'b0;
            pc_load  = 1'b0;
            pc_imm   = 1'b0;
        end
    end

    // Decode output register: flush beats fetch, fetch beats drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid  <= 1'b0;
            ir_opcode <= 8'h00;
            ir_imm    <= 8'h00;
            ir_pc     <= 8'h00;
        end else if (do_flush) begin
            ir_valid <= 1'b0;
        end else if (do_fetch) begin
            ir_valid  <= 1'b1;
            ir_opcode <= imem_byte0;
            ir_imm    <= is_imm ? imem_byte1 : 8'h00;
            ir_pc     <= pc;
        end else if (ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

    // Count handshakes with decode; a handshake coinciding with a redirect is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0000;
        end else if (ir_valid && ir_ready && !br_taken) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_byte0;
    logic [7:0]  imem_byte1;
    logic        pc_en;
    logic        pc_load;
    logic        pc_imm;
    logic [7:0]  pc_target;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [7:0]  ir_opcode;
    logic [7:0]  ir_imm;
    logic [7:0]  ir_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0]  mem [0:255];
    logic [7:0]  addr1;
    int          total = 0;
    int          bad = 0;

    fetch_unit #(.HALT_OP(8'hFF), .IMM_BIT(7)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_addr(imem_addr),
        .imem_byte0(imem_byte0), .imem_byte1(imem_byte1),
        .pc_en(pc_en), .pc_load(pc_load), .pc_imm(pc_imm), .pc_target(pc_target),
        .br_taken(br_taken), .br_target(br_target),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_opcode(ir_opcode),
        .ir_imm(ir_imm), .ir_pc(ir_pc), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory with wrapping second-byte address.
    assign addr1      = imem_addr + 8'd1;
    assign imem_byte0 = mem[imem_addr];
    assign imem_byte1 = mem[addr1];

    // Program counter model driven by the fetch unit controls.
    always @(posedge clk) begin
        if (rst) pc <= 8'h00;
        else if (pc_en) pc <= pc_load ? pc_target : pc + (pc_imm ? 8'd2 : 8'd1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1; br_taken = 1'b0; br_target = 8'h00; ir_ready = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ir_valid); end
        total++; if ({ir_opcode, ir_imm, ir_pc} !== 24'h0) begin bad++; $display("FAIL reset_ir got=%h want=000000", {ir_opcode, ir_imm, ir_pc}); end
        total++; if (fetch_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", fetch_count); end
        total++; if ({halted, pc_en, pc_load, pc_imm} !== 4'b0) begin bad++; $display("FAIL reset_ctl got=%b want=0000", {halted, pc_en, pc_load, pc_imm}); end
        total++; if (pc_target !== 8'h00) begin bad++; $display("FAIL reset_target got=%h want=00", pc_target); end
    endtask

    task automatic test_seq_fetch();
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        do_reset();
        total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL boot_pc_en got=%0b want=0", pc_en); end
        cyc();
        total++; if ({pc_en, pc_imm, ir_valid} !== 3'b100) begin bad++; $display("FAIL run_first got=%b want=100", {pc_en, pc_imm, ir_valid}); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL imem_addr got=%h want=00", imem_addr); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if ({ir_valid, ir_pc, ir_opcode} !== {1'b1, 8'(k), 8'(k + 1)})
                begin bad++; $display("FAIL seq_ir%0d got=%b/%h/%h want=1/%h/%h", k, ir_valid, ir_pc, ir_opcode, 8'(k), 8'(k + 1)); end
            total++; if (fetch_count !== 16'(k)) begin bad++; $display("FAIL seq_count%0d got=%0d want=%0d", k, fetch_count, k); end
        end
        cyc();
        total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL seq_count3 got=%0d want=3", fetch_count); end
    endtask

    task automatic test_immediate();
        clear_mem();
        mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'h01;
        do_reset();
        cyc();
        total++; if ({pc_en, pc_imm} !== 2'b11) begin bad++; $display("FAIL imm_ctl got=%b want=11", {pc_en, pc_imm}); end
        cyc();
        total++; if ({ir_opcode, ir_imm, ir_pc} !== 24'h853C00) begin bad++; $display("FAIL imm_ir got=%h want=853c00", {ir_opcode, ir_imm, ir_pc}); end
        total++; if (pc !== 8'h02) begin bad++; $display("FAIL imm_pc got=%h want=02", pc); end
        cyc();
        total++; if ({ir_opcode, ir_imm, ir_pc} !== 24'h010002) begin bad++; $display("FAIL imm_next got=%h want=010002", {ir_opcode, ir_imm, ir_pc}); end
    endtask

    task automatic test_backpressure_redirect();
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04; mem[8'h40] = 8'h55;
        do_reset();
        cyc(); cyc(); cyc();
        ir_ready = 1'b0;
        #1;
        total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL stall_pc_en got=%0b want=0", pc_en); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if ({ir_valid, ir_pc, ir_opcode, pc_en, pc} !== {1'b1, 8'h01, 8'h02, 1'b0, 8'h02})
                begin bad++; $display("FAIL stall%0d got=%b/%h/%h/%b/%h want=1/01/02/0/02", k, ir_valid, ir_pc, ir_opcode, pc_en, pc); end
        end
        ir_ready = 1'b1;
        cyc();
        total++; if ({ir_valid, ir_pc, ir_opcode} !== {1'b1, 8'h02, 8'h03}) begin bad++; $display("FAIL release got=%b/%h/%h want=1/02/03", ir_valid, ir_pc, ir_opcode); end
        total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL release_count got=%0d want=2", fetch_count); end
        ir_ready = 1'b0; br_taken = 1'b1; br_target = 8'h40;
        #1;
        total++; if ({pc_en, pc_load, pc_imm, pc_target} !== {3'b110, 8'h40}) begin bad++; $display("FAIL br_ctl got=%b/%h want=110/40", {pc_en, pc_load, pc_imm}, pc_target); end
        cyc();
        br_taken = 1'b0; ir_ready = 1'b1;
        #1;
        total++; if ({ir_valid, pc} !== {1'b0, 8'h40}) begin bad++; $display("FAIL br_flush got=%b/%h want=0/40", ir_valid, pc); end
        total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL br_count got=%0d want=2", fetch_count); end
        cyc();
        total++; if ({ir_valid, ir_pc, ir_opcode} !== {1'b1, 8'h40, 8'h55}) begin bad++; $display("FAIL br_target_fetch got=%b/%h/%h want=1/40/55", ir_valid, ir_pc, ir_opcode); end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF; mem[4] = 8'h00; mem[8'h10] = 8'h22;
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        total++; if ({pc, pc_en} !== {8'h03, 1'b0}) begin bad++; $display("FAIL halt_read got=%h/%b want=03/0", pc, pc_en); end
        cyc();
        total++; if ({ir_valid, ir_opcode, ir_imm, ir_pc} !== {1'b1, 24'hFF0003}) begin bad++; $display("FAIL halt_ir got=%b/%h/%h/%h want=1/ff/00/03", ir_valid, ir_opcode, ir_imm, ir_pc); end
        total++; if ({halted, pc_en} !== 2'b10) begin bad++; $display("FAIL halt_state got=%b want=10", {halted, pc_en}); end
        cyc();
        total++; if ({ir_valid, halted, pc_en, pc} !== {3'b010, 8'h03}) begin bad++; $display("FAIL halt_drain got=%b/%h want=010/03", {ir_valid, halted, pc_en}, pc); end
        total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL halt_count got=%0d want=4", fetch_count); end
        br_taken = 1'b1; br_target = 8'h10;
        #1;
        total++; if ({pc_en, pc_load, pc_target} !== {2'b11, 8'h10}) begin bad++; $display("FAIL halt_br got=%b/%h want=11/10", {pc_en, pc_load}, pc_target); end
        cyc();
        br_taken = 1'b0;
        #1;
        total++; if ({halted, pc} !== {1'b0, 8'h10}) begin bad++; $display("FAIL halt_exit got=%b/%h want=0/10", halted, pc); end
        cyc();
        total++; if ({ir_valid, ir_pc, ir_opcode} !== {1'b1, 8'h10, 8'h22}) begin bad++; $display("FAIL halt_refetch got=%b/%h/%h want=1/10/22", ir_valid, ir_pc, ir_opcode); end
    endtask

    task automatic test_wrap_reset();
        clear_mem();
        do_reset();
        cyc();
        br_taken = 1'b1; br_target = 8'hFF;
        cyc();
        br_taken = 1'b0;
        mem[8'hFF] = 8'h81; mem[0] = 8'h7E; mem[1] = 8'h00;
        #1;
        total++; if ({imem_addr, pc_en, pc_imm} !== {8'hFF, 2'b11}) begin bad++; $display("FAIL wrap_ctl got=%h/%b want=ff/11", imem_addr, {pc_en, pc_imm}); end
        cyc();
        total++; if ({ir_opcode, ir_imm, ir_pc} !== 24'h817EFF) begin bad++; $display("FAIL wrap_ir got=%h want=817eff", {ir_opcode, ir_imm, ir_pc}); end
        total++; if (pc !== 8'h01) begin bad++; $display("FAIL wrap_pc got=%h want=01", pc); end
        cyc();
        total++; if ({ir_valid, ir_pc, fetch_count} !== {1'b1, 8'h01, 16'd1}) begin bad++; $display("FAIL wrap_next got=%b/%h/%0d want=1/01/1", ir_valid, ir_pc, fetch_count); end
        ir_ready = 1'b0; rst = 1'b1; br_taken = 1'b1; br_target = 8'h77;
        cyc();
        rst = 1'b0;
        #1;
        total++; if ({ir_valid, fetch_count} !== 17'h0) begin bad++; $display("FAIL rst_mid got=%b/%0d want=0/0", ir_valid, fetch_count); end
        total++; if ({pc_en, pc_load, halted} !== 3'b000) begin bad++; $display("FAIL rst_boot got=%b want=000", {pc_en, pc_load, halted}); end
        br_taken = 1'b0; ir_ready = 1'b1;
        cyc();
        total++; if ({pc_en, ir_valid} !== 2'b10) begin bad++; $display("FAIL rst_run got=%b want=10", {pc_en, ir_valid}); end
    endtask

    initial begin
        rst = 1'b1; br_taken = 1'b0; br_target = 8'h00; ir_ready = 1'b1;
        clear_mem();
        test_reset();
        test_seq_fetch();
        test_immediate();
        test_backpressure_redirect();
        test_halt();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
